dumbrv_gpio_irq: RTL and testbench

//  Parametrised GPIO peripheral on the dumbrv stray memory bus.
//  - Per-pin direction, output data, and atomic SET/CLR/TGL writes.
//  - Synchronised inputs with rising/falling edge detection.
//  - Sticky write-1-to-clear pending flags and one level interrupt, irq_o.

---
 rtl/dumbrv_gpio_pkg.sv | 52 +++++
 rtl/dumbrv_gpio_irq_if.sv | 22 ++
 rtl/dumbrv_gpio_sync.sv | 53 +++++
 rtl/dumbrv_gpio_irq.sv | 169 ++++++++++++++++
 tb/tb_dumbrv_gpio_irq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dumbrv_gpio_pkg.sv
// Shared constants for the dumbrv GPIO peripheral: register offsets,
// EN field split, stray access size encodings and small mask helpers.
package dumbrv_gpio_pkg;

  // Register word offsets, addr[4:2]
  localparam logic [2:0] REG_DIN  = 3'd0;
  localparam logic [2:0] REG_DOUT = 3'd1;
  localparam logic [2:0] REG_OE   = 3'd2;
  localparam logic [2:0] REG_SET  = 3'd3;
  localparam logic [2:0] REG_CLR  = 3'd4;
  localparam logic [2:0] REG_TGL  = 3'd5;
  localparam logic [2:0] REG_EN   = 3'd6;
  localparam logic [2:0] REG_PEND = 3'd7;

  // EN register: rise enables in [15:0], fall enables from this bit up
  localparam int EN_FALL_LSB = 16;

  // stray_size_i encodings (bytes per access)
  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  // Implemented EN bits: only pins 0..15 can have edge enables
  function automatic logic [31:0] en_mask(input int width);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < EN_FALL_LSB; i++) begin
      if (i < width) begin
        m[i]               = 1'b1;
        m[EN_FALL_LSB + i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Read-data mask for a given access size; unsupported sizes read 0
  function automatic logic [31:0] size_mask(input logic [2:0] size);
    logic [31:0] m;
    case (size)
      SIZE_BYTE: m = 32'h0000_00FF;
      SIZE_HALF: m = 32'h0000_FFFF;
      SIZE_WORD: m = 32'hFFFF_FFFF;
      default:   m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic size_ok(input logic [2:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
  endfunction

endpackage

// File: rtl/dumbrv_gpio_irq_if.sv
// Stray memory bus request/response bundle as seen by a peripheral.
interface dumbrv_gpio_irq_if;
  logic        stray_en_i;
  logic        stray_wr_i;
  logic [15:0] stray_addr_i;
  logic [2:0]  stray_size_i;
  logic [31:0] stray_data_i;
  logic [31:0] stray_data_o;
  logic        stray_done_o;

  // Requester side (core or testbench)
  modport master (
    output stray_en_i, stray_wr_i, stray_addr_i, stray_size_i, stray_data_i,
    input  stray_data_o, stray_done_o
  );

  // Peripheral side
  modport slave (
    input  stray_en_i, stray_wr_i, stray_addr_i, stray_size_i, stray_data_i,
    output stray_data_o, stray_done_o
  );
endinterface

// File: rtl/dumbrv_gpio_sync.sv
// Input synchroniser, one-cycle delayed copy and edge detection.
// Edges are held off until the chain has filled after reset so that a pin
// sitting high through reset does not look like a rising edge.
module dumbrv_gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  localparam int PRIME = SYNC_STAGES + 1;
  localparam int CW    = $clog2(PRIME + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_s_d;
  logic [CW-1:0]    r_prime;
  logic [WIDTH-1:0] w_s;
  logic             w_primed;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_primed = (r_prime == CW'(PRIME));

  // Synchroniser chain plus delayed copy of the synchronised value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_s_d <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_s_d <= w_s;
    end
  end

  // Saturating prime counter; edges are valid once it reaches PRIME
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime <= '0;
    end else if (!w_primed) begin
      r_prime <= r_prime + CW'(1);
    end
  end

  assign o_s    = w_s;
  assign o_rise = w_primed ? (w_s & ~r_s_d) : '0;
  assign o_fall = w_primed ? (~w_s & r_s_d) : '0;

endmodule

// File: rtl/dumbrv_gpio_irq.sv
// GPIO peripheral on the dumbrv stray bus: direction/data registers with
// atomic SET/CLR/TGL, synchronised inputs, edge-triggered sticky pending
// flags and a single level interrupt.
module dumbrv_gpio_irq
  import dumbrv_gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [15:0]      BASE        = 16'hFFE0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dumbrv_gpio_irq_if.slave     bus,
  input  logic [WIDTH-1:0]     gpio_i,
  output logic [WIDTH-1:0]     gpio_o,
  output logic [WIDTH-1:0]     gpio_oe_o,
  output logic                 irq_o
);

  localparam int          NIRQ    = (WIDTH < EN_FALL_LSB) ? WIDTH : EN_FALL_LSB;
  localparam logic [31:0] EN_MASK = en_mask(WIDTH);

  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_oe;
  logic [31:0]      r_en;
  logic [WIDTH-1:0] r_pend;
  logic             r_done;
  logic [31:0]      r_rdata;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_rise_en;
  logic [WIDTH-1:0] w_fall_en;

  logic [1:0]       w_off;
  logic [2:0]       w_word;
  logic             w_in_win;
  logic             w_accept;
  logic             w_hit;
  logic             w_wr;
  logic             w_rd;
  logic [3:0]       w_lane;
  logic [31:0]      w_bmask;
  logic [31:0]      w_wd;
  logic [WIDTH-1:0] w_wd_n;
  logic [WIDTH-1:0] w_bm_n;
  logic [31:0]      w_rmux;
  logic [31:0]      w_rdata;

  logic [WIDTH-1:0] w_dout_nx;
  logic [WIDTH-1:0] w_oe_nx;
  logic [31:0]      w_en_nx;
  logic [WIDTH-1:0] w_pend_clr;
  logic [WIDTH-1:0] w_pend_set;

  dumbrv_gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (gpio_i),
    .o_s     (w_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Per-pin edge enables; pins at or above EN_FALL_LSB have no IRQ
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_en
    if (gi < NIRQ) begin : g_irq
      assign w_rise_en[gi] = r_en[gi];
      assign w_fall_en[gi] = r_en[EN_FALL_LSB + gi];
    end else begin : g_noirq
      assign w_rise_en[gi] = 1'b0;
      assign w_fall_en[gi] = 1'b0;
    end
  end

  assign w_off    = bus.stray_addr_i[1:0];
  assign w_word   = bus.stray_addr_i[4:2];
  assign w_in_win = (bus.stray_addr_i[15:5] == BASE[15:5]);
  assign w_accept = bus.stray_en_i & ~r_done;
  assign w_hit    = w_accept & w_in_win & size_ok(bus.stray_size_i);
  assign w_wr     = w_hit & bus.stray_wr_i;
  assign w_rd     = w_hit & ~bus.stray_wr_i;

  // Byte-lane selection; accesses that run past byte 3 are truncated
  always_comb begin
    w_lane = '0;
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(w_off)) && (k < int'(w_off) + int'(bus.stray_size_i))) begin
        w_lane[k] = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      w_bmask[8*k +: 8] = {8{w_lane[k]}};
    end
  end

  // Right-aligned write data steered onto the selected lanes
  assign w_wd   = (bus.stray_data_i << {w_off, 3'b000}) & w_bmask;
  assign w_wd_n = w_wd[WIDTH-1:0];
  assign w_bm_n = w_bmask[WIDTH-1:0];

  // Read mux, then shift down to the access offset and trim to size
  always_comb begin
    w_rmux = '0;
    case (w_word)
      REG_DIN:  w_rmux = 32'(w_s);
      REG_DOUT: w_rmux = 32'(r_dout);
      REG_OE:   w_rmux = 32'(r_oe);
      REG_EN:   w_rmux = r_en;
      REG_PEND: w_rmux = 32'(r_pend);
      default:  w_rmux = '0;
    endcase
    w_rdata = (w_rmux >> {w_off, 3'b000}) & size_mask(bus.stray_size_i);
  end

  // Next-state for the writable registers
  always_comb begin
    w_dout_nx  = r_dout;
    w_oe_nx    = r_oe;
    w_en_nx    = r_en;
    w_pend_clr = '0;
    if (w_wr) begin
      case (w_word)
        REG_DOUT: w_dout_nx  = (r_dout & ~w_bm_n) | w_wd_n;
        REG_OE:   w_oe_nx    = (r_oe & ~w_bm_n) | w_wd_n;
        REG_SET:  w_dout_nx  = r_dout | w_wd_n;
        REG_CLR:  w_dout_nx  = r_dout & ~w_wd_n;
        REG_TGL:  w_dout_nx  = r_dout ^ w_wd_n;
        REG_EN:   w_en_nx    = ((r_en & ~w_bmask) | w_wd) & EN_MASK;
        REG_PEND: w_pend_clr = w_wd_n;
        default:  w_dout_nx  = r_dout;
      endcase
    end
  end

  // An enabled edge in the same cycle as a W1C keeps the flag set
  assign w_pend_set = (w_rise & w_rise_en) | (w_fall & w_fall_en);

  // Register file, pending flags and single-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= RESET_OUT;
      r_oe    <= '0;
      r_en    <= '0;
      r_pend  <= '0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_dout  <= w_dout_nx;
      r_oe    <= w_oe_nx;
      r_en    <= w_en_nx;
      r_pend  <= (r_pend & ~w_pend_clr) | w_pend_set;
      r_done  <= w_accept;
      r_rdata <= w_rd ? w_rdata : '0;
    end
  end

  assign bus.stray_done_o = r_done;
  assign bus.stray_data_o = r_rdata;
  assign gpio_o           = r_dout;
  assign gpio_oe_o        = r_oe;
  assign irq_o            = |(r_pend & (w_rise_en | w_fall_en));

endmodule

// File: tb/tb_dumbrv_gpio_irq.sv
// Directed testbench for dumbrv_gpio_irq (WIDTH=16, RESET_OUT=16'h00A5).
module tb_dumbrv_gpio_irq;
  import dumbrv_gpio_pkg::*;

  localparam int          WIDTH = 16;
  localparam logic [15:0] BASE  = 16'hFFE0;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] gpio_i;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] gpio_oe_o;
  logic             irq_o;

  int errors = 0;
  int checks = 0;

  dumbrv_gpio_irq_if bus_if ();

  dumbrv_gpio_irq #(
    .WIDTH       (WIDTH),
    .BASE        (BASE),
    .SYNC_STAGES (2),
    .RESET_OUT   (16'h00A5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with done low; returns one negedge after done seen.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [2:0] sz,
                      input logic [31:0] d, output logic [31:0] rd, output int cyc);
    bus_if.stray_en_i   = 1'b1;
    bus_if.stray_wr_i   = wr;
    bus_if.stray_addr_i = a;
    bus_if.stray_size_i = sz;
    bus_if.stray_data_i = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus_if.stray_done_o && cyc < 8);
    rd = bus_if.stray_data_o;
    bus_if.stray_en_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int cyc;
    logic irq_seen;
    gpio_i = 16'h00FF;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gpio_o !== 16'h00A5) begin errors++; $display("FAIL reset_dout got=%h exp=00a5", gpio_o); end
    checks++; if (gpio_oe_o !== 16'h0000) begin errors++; $display("FAIL reset_oe got=%h exp=0000", gpio_oe_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    checks++; if (bus_if.stray_done_o !== 1'b0 || bus_if.stray_data_o !== 32'h0)
      begin errors++; $display("FAIL reset_bus done=%b data=%h exp 0/0", bus_if.stray_done_o, bus_if.stray_data_o); end
    rst_n = 1'b1;
    // Enable all edges on pins 0..7 right away, while the chain is still filling
    xfer(1'b1, BASE + 16'h18, SIZE_WORD, 32'h00FF_00FF, rd, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL reset_en_latency got=%0d exp=1", cyc); end
    irq_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (irq_o) irq_seen = 1'b1;
    end
    checks++; if (irq_seen !== 1'b0) begin errors++; $display("FAIL prime_irq got=%b exp=0", irq_seen); end
    xfer(1'b0, BASE + 16'h1C, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL prime_pend got=%h exp=00000000", rd); end
    xfer(1'b0, BASE, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL din_read got=%h exp=000000ff", rd); end
  endtask

  task automatic test_dout_ops();
    logic [31:0] rd;
    int cyc;
    logic [15:0] addrs [4];
    logic [31:0] data  [4];
    logic [15:0] exps  [4];
    addrs = '{BASE + 16'h04, BASE + 16'h0C, BASE + 16'h10, BASE + 16'h14};
    data  = '{32'h5A, 32'h81, 32'h02, 32'hFF};
    exps  = '{16'h005A, 16'h00DB, 16'h00D9, 16'h0026};
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, addrs[i], SIZE_WORD, data[i], rd, cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL dout_latency[%0d] got=%0d exp=1", i, cyc); end
      checks++; if (gpio_o !== exps[i]) begin errors++; $display("FAIL dout_op[%0d] got=%h exp=%h", i, gpio_o, exps[i]); end
    end
    xfer(1'b1, BASE + 16'h08, SIZE_WORD, 32'h0000_F00F, rd, cyc);
    checks++; if (gpio_oe_o !== 16'hF00F) begin errors++; $display("FAIL oe_write got=%h exp=f00f", gpio_oe_o); end
    xfer(1'b0, BASE + 16'h0C, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL set_reads_zero got=%h exp=00000000", rd); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    int cyc;
    logic [2:0] irq_hist;
    xfer(1'b1, BASE + 16'h18, SIZE_WORD, 32'h0001_0001, rd, cyc);
    gpio_i = 16'h0000;   // falls on pins 0..7, only pin 0 enabled
    repeat (5) @(negedge clk);
    xfer(1'b0, BASE + 16'h1C, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL fall_masked_pend got=%h exp=00000001", rd); end
    xfer(1'b1, BASE + 16'h1C, SIZE_WORD, 32'h0000_FFFF, rd, cyc);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_all_irq got=%b exp=0", irq_o); end
    gpio_i[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      irq_hist[i] = irq_o;
    end
    checks++; if (irq_hist !== 3'b100) begin errors++; $display("FAIL rise_irq_timing got=%b exp=100", irq_hist); end
    xfer(1'b0, BASE + 16'h1C, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL rise_pend got=%h exp=00000001", rd); end
    xfer(1'b1, BASE + 16'h1C, SIZE_BYTE, 32'h01, rd, cyc);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b exp=0", irq_o); end
    gpio_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL fall_irq got=%b exp=1", irq_o); end
    xfer(1'b0, BASE + 16'h1C, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL fall_pend got=%h exp=00000001", rd); end
    xfer(1'b1, BASE + 16'h1C, SIZE_WORD, 32'h1, rd, cyc);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd;
    int cyc;
    gpio_i[0] = 1'b1;
    // Rise reaches the PEND logic on the third edge; the W1C is accepted on it
    repeat (2) @(negedge clk);
    xfer(1'b1, BASE + 16'h1C, SIZE_WORD, 32'h1, rd, cyc);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL collide_irq got=%b exp=1", irq_o); end
    xfer(1'b0, BASE + 16'h1C, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL collide_pend got=%h exp=00000001", rd); end
    xfer(1'b1, BASE + 16'h1C, SIZE_WORD, 32'h1, rd, cyc);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL collide_clear got=%b exp=0", irq_o); end
  endtask

  task automatic test_subword();
    logic [31:0] rd;
    int cyc;
    xfer(1'b1, BASE + 16'h04, SIZE_WORD, 32'h0000_1234, rd, cyc);
    xfer(1'b0, BASE + 16'h05, SIZE_BYTE, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0012) begin errors++; $display("FAIL byte_read got=%h exp=00000012", rd); end
    xfer(1'b0, BASE + 16'h04, SIZE_HALF, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL half_read got=%h exp=00001234", rd); end
    xfer(1'b0, BASE - 16'h4, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (cyc !== 1 || rd !== 32'h0)
      begin errors++; $display("FAIL oow_read cyc=%0d data=%h exp 1/00000000", cyc, rd); end
    xfer(1'b1, 16'hFFC4, SIZE_WORD, 32'h0000_FFFF, rd, cyc);
    checks++; if (gpio_o !== 16'h1234) begin errors++; $display("FAIL oow_write got=%h exp=1234", gpio_o); end
    xfer(1'b1, BASE + 16'h04, 3'd3, 32'h0000_FFFF, rd, cyc);
    checks++; if (cyc !== 1 || gpio_o !== 16'h1234)
      begin errors++; $display("FAIL size3_write cyc=%0d dout=%h exp 1/1234", cyc, gpio_o); end
    xfer(1'b0, BASE + 16'h04, 3'd3, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL size3_read got=%h exp=00000000", rd); end
    xfer(1'b1, BASE + 16'h05, SIZE_BYTE, 32'h0000_00AB, rd, cyc);
    checks++; if (gpio_o !== 16'hAB34) begin errors++; $display("FAIL byte_write got=%h exp=ab34", gpio_o); end
    xfer(1'b0, BASE + 16'h18, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0001_0001) begin errors++; $display("FAIL en_read got=%h exp=00010001", rd); end
    xfer(1'b0, BASE + 16'h1A, SIZE_HALF, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL en_hi_read got=%h exp=00000001", rd); end
  endtask

  task automatic test_reset_mid_request();
    logic [31:0] rd;
    int cyc;
    int done_cnt;
    bus_if.stray_en_i   = 1'b1;
    bus_if.stray_wr_i   = 1'b0;
    bus_if.stray_addr_i = BASE + 16'h04;
    bus_if.stray_size_i = SIZE_WORD;
    bus_if.stray_data_i = 32'h0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.stray_done_o) done_cnt++;
    end
    checks++; if (done_cnt !== 0 || bus_if.stray_data_o !== 32'h0)
      begin errors++; $display("FAIL midreq_done count=%0d data=%h exp 0/00000000", done_cnt, bus_if.stray_data_o); end
    checks++; if (gpio_o !== 16'h00A5 || gpio_oe_o !== 16'h0000 || irq_o !== 1'b0)
      begin errors++; $display("FAIL midreq_regs dout=%h oe=%h irq=%b exp 00a5/0000/0", gpio_o, gpio_oe_o, irq_o); end
    bus_if.stray_en_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(1'b0, BASE + 16'h18, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreq_en got=%h exp=00000000", rd); end
    xfer(1'b0, BASE + 16'h1C, SIZE_WORD, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreq_pend got=%h exp=00000000", rd); end
  endtask

  initial begin
    bus_if.stray_en_i   = 1'b0;
    bus_if.stray_wr_i   = 1'b0;
    bus_if.stray_addr_i = '0;
    bus_if.stray_size_i = '0;
    bus_if.stray_data_i = '0;
    gpio_i = '0;
    rst_n  = 1'b0;
    test_reset();
    test_dout_ops();
    test_edge_irq();
    test_w1c_collision();
    test_subword();
    test_reset_mid_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
